// File: rtl/user_param_master_if.sv
// Handshake, SPI bus and parameter read-back signals of the user_param_master SPI master.
interface user_param_master_if;
  logic       start;
  logic       rw;
  logic [6:0] len;
  logic [7:0] wr_data;
  logic       wr_req;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       done;
  logic       spi_cs;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] param0;
  logic [7:0] param1;
  logic [7:0] param2;
  logic [7:0] param3;
  logic [7:0] param4;
  logic [7:0] param5;
  logic [7:0] param6;

  modport master (
    input  start, rw, len, wr_data, spi_miso,
    output wr_req, rd_data, rd_valid, busy, done, spi_cs, spi_sclk, spi_mosi,
    output param0, param1, param2, param3, param4, param5, param6
  );

  modport slave (
    output start, rw, len, wr_data, spi_miso,
    input  wr_req, rd_data, rd_valid, busy, done, spi_cs, spi_sclk, spi_mosi,
    input  param0, param1, param2, param3, param4, param5, param6
  );
endinterface

// File: rtl/user_param_master.sv
// SPI mode-0 master: command byte {rw,len} followed by len payload bytes in one CS window.
// Define USER_PARAM_MASTER_MIRROR_EN to mirror read payload bytes 0..6 into param0..param6.
module user_param_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned BYTE_GAP = 8
) (
  input logic                 clk,
  input logic                 rst,
  user_param_master_if.master bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BYTE_GAP - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [7:0] PARAM_RST [7] = '{8'h00, 8'hC2, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08};

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             rw_q, rw_d;
  logic [6:0]       rem_q, rem_d;
  logic             cmd_q, cmd_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wr_req_q, wr_req_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       rd_data_q, rd_data_d;
`ifdef USER_PARAM_MASTER_MIRROR_EN
  logic [7:0]       param_q [7];
  logic [7:0]       param_d [7];
  logic [2:0]       idx_q, idx_d;
`endif

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rw_d       = rw_q;
    rem_d      = rem_q;
    cmd_d      = cmd_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    wr_req_d   = 1'b0;
    rd_valid_d = 1'b0;
`ifdef USER_PARAM_MASTER_MIRROR_EN
    param_d    = param_q;
    idx_d      = idx_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rw_d    = bus.rw;
          rem_d   = bus.len;
          tx_d    = {bus.rw, bus.len};
          mosi_d  = bus.rw;
          cmd_d   = 1'b1;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_SETUP;
`ifdef USER_PARAM_MASTER_MIRROR_EN
          idx_d   = 3'd0;
`endif
        end
      end
      S_SETUP, S_GAP: begin
        // wr_data is captured on the edge that ends the wr_req cycle
        if (wr_req_q) begin
          tx_d   = bus.wr_data;
          mosi_d = bus.wr_data[7];
        end
        if (cnt_q == ((state_q == S_SETUP) ? SETUP_LAST : GAP_LAST)) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], bus.spi_miso};
          bit_d   = 3'd0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SHIFT: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q != 3'd7) begin
              tx_d   = {tx_q[6:0], 1'b0};
              mosi_d = tx_q[6];
            end
          end else if (bit_q != 3'd7) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], bus.spi_miso};
            bit_d  = bit_q + 3'd1;
          end else begin
            // Byte complete after its final low phase
            cmd_d  = 1'b0;
            tx_d   = '0;
            mosi_d = 1'b0;
            if (!cmd_q && rw_q) begin
              rd_data_d  = rx_q;
              rd_valid_d = 1'b1;
`ifdef USER_PARAM_MASTER_MIRROR_EN
              if (idx_q != 3'd7) begin
                param_d[idx_q] = rx_q;
                idx_d          = idx_q + 3'd1;
              end
`endif
            end
            if (rem_q != 7'd0) begin
              rem_d    = rem_q - 7'd1;
              wr_req_d = !rw_q;
              state_d  = S_GAP;
            end else begin
              state_d = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rw_q       <= 1'b0;
      rem_q      <= '0;
      cmd_q      <= 1'b0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_req_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
`ifdef USER_PARAM_MASTER_MIRROR_EN
      param_q    <= PARAM_RST;
      idx_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rw_q       <= rw_d;
      rem_q      <= rem_d;
      cmd_q      <= cmd_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_req_q   <= wr_req_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
`ifdef USER_PARAM_MASTER_MIRROR_EN
      param_q    <= param_d;
      idx_q      <= idx_d;
`endif
    end
  end

  assign bus.spi_cs   = cs_q;
  assign bus.spi_sclk = sclk_q;
  assign bus.spi_mosi = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wr_req   = wr_req_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

`ifdef USER_PARAM_MASTER_MIRROR_EN
  assign bus.param0 = param_q[0];
  assign bus.param1 = param_q[1];
  assign bus.param2 = param_q[2];
  assign bus.param3 = param_q[3];
  assign bus.param4 = param_q[4];
  assign bus.param5 = param_q[5];
  assign bus.param6 = param_q[6];
`else
  assign bus.param0 = PARAM_RST[0];
  assign bus.param1 = PARAM_RST[1];
  assign bus.param2 = PARAM_RST[2];
  assign bus.param3 = PARAM_RST[3];
  assign bus.param4 = PARAM_RST[4];
  assign bus.param5 = PARAM_RST[5];
  assign bus.param6 = PARAM_RST[6];
`endif

endmodule

// File: tb/tb_user_param_master.sv
// Directed bench for user_param_master: transaction table against a mode-0 SPI slave
// model, plus busy-start, mid-byte reset and parameter read-back sequences.
module tb_user_param_master;

  typedef struct {
    logic            rw;
    logic [6:0]      len;
    logic [6:0][7:0] wdat;    // wdat[k] is payload byte k
    logic [6:0][7:0] exp_rd;  // exp_rd[k] is read byte k
    int              exp_cs_low;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  user_param_master_if bus();

  user_param_master dut (.clk(clk), .rst(rst), .bus(bus));

  initial forever #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Slave model and bus monitor state
  logic [7:0]      mem [128];
  logic [7:0]      mosi_log [$];
  logic [7:0]      rd_log [$];
  logic [6:0][7:0] wdat_cur = '0;
  int   rises = 0, wr_reqs = 0, dones = 0, cs_low_cycles = 0, cs_falls = 0;
  int   bitcnt = 0, bytecnt = 0, widx = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;
  logic [7:0] in_sh = '0, cmd = '0, cur_out = '0;
  logic [6:0] addr = '0;

  initial begin
    bus.spi_miso = 1'b0;
    bus.wr_data  = 8'h00;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[1] = 8'hC2; mem[2] = 8'h01; mem[6] = 8'h08;
    forever begin
      @(negedge clk);
      if (bus.spi_cs) begin
        bitcnt = 0;
        bus.spi_miso = 1'b0;
      end else begin
        cs_low_cycles++;
        if (prev_cs) begin
          cs_falls++; bitcnt = 0; bytecnt = 0; cur_out = 8'h00; widx = 0;
          bus.spi_miso = 1'b0;
        end
        if (bus.spi_sclk && !prev_sclk) begin
          rises++;
          in_sh = {in_sh[6:0], bus.spi_mosi};
          bitcnt++;
          if (bitcnt == 8) begin
            bitcnt = 0;
            mosi_log.push_back(in_sh);
            if (bytecnt == 0) begin
              cmd = in_sh; addr = 7'd0;
            end else if (!cmd[7]) begin
              mem[addr] = in_sh; addr = addr + 7'd1;
            end
            bytecnt++;
            if (cmd[7]) begin
              cur_out = mem[addr]; addr = addr + 7'd1;
              bus.spi_miso = cur_out[7];
            end
          end
        end else if (!bus.spi_sclk && prev_sclk && bitcnt != 0) begin
          bus.spi_miso = cur_out[7-bitcnt];
        end
      end
      if (bus.wr_req) begin
        wr_reqs++;
        if (widx < 7) bus.wr_data = wdat_cur[widx];
        widx++;
      end
      if (bus.rd_valid) rd_log.push_back(bus.rd_data);
      if (bus.done) dones++;
      prev_cs   = bus.spi_cs;
      prev_sclk = bus.spi_sclk;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] param_at(input int k);
    case (k)
      0: return bus.param0;
      1: return bus.param1;
      2: return bus.param2;
      3: return bus.param3;
      4: return bus.param4;
      5: return bus.param5;
      default: return bus.param6;
    endcase
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " busy_clear"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic pulse_start(input logic rw, input logic [6:0] len);
    @(negedge clk);
    bus.rw = rw; bus.len = len; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int r0, w0, d0, c0, f0, m0, q0, nb;
    logic [7:0] exp_b;
    @(posedge clk);
    r0 = rises; w0 = wr_reqs; d0 = dones; c0 = cs_low_cycles; f0 = cs_falls;
    m0 = mosi_log.size(); q0 = rd_log.size();
    wdat_cur = v.wdat;
    pulse_start(v.rw, v.len);
    wait_idle(tag);
    @(posedge clk);
    nb = int'(v.len) + 1;
    check({tag, " cs_low"},   32'(cs_low_cycles - c0), 32'(v.exp_cs_low));
    check({tag, " rises"},    32'(rises - r0), 32'(8 * nb));
    check({tag, " wr_req"},   32'(wr_reqs - w0), v.rw ? 32'd0 : 32'(v.len));
    check({tag, " rd_valid"}, 32'(rd_log.size() - q0), v.rw ? 32'(v.len) : 32'd0);
    check({tag, " done"},     32'(dones - d0), 32'd1);
    check({tag, " cs_falls"}, 32'(cs_falls - f0), 32'd1);
    check({tag, " mosi_cnt"}, 32'(mosi_log.size() - m0), 32'(nb));
    for (int k = 0; k < nb; k++) begin
      exp_b = (k == 0) ? {v.rw, v.len} : (v.rw ? 8'h00 : v.wdat[k-1]);
      if (m0 + k < mosi_log.size())
        check($sformatf("%s mosi[%0d]", tag, k), 32'(mosi_log[m0+k]), 32'(exp_b));
    end
    if (v.rw) begin
      for (int k = 0; k < int'(v.len); k++) begin
        if (q0 + k < rd_log.size())
          check($sformatf("%s rd[%0d]", tag, k), 32'(rd_log[q0+k]), 32'(v.exp_rd[k]));
      end
    end
  endtask

  vec_t vecs [7];
  vec_t post;
  logic [7:0] rst_params [7];
  logic [7:0] exp_p;
  int r0, d0, f0, m0, q0, n;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.rw = 1'b0; bus.len = 7'd0;
    rst_params = '{8'h00, 8'hC2, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08};

    // rw, len, wdat (byte 6..0), exp_rd (byte 6..0), cs low cycles
    vecs[0] = '{1'b1, 7'd7, 56'h0, 56'h08_00_00_00_01_C2_00, 576};
    vecs[1] = '{1'b0, 7'd3, 56'h00_00_00_00_FF_5A_A5, 56'h0, 288};
    vecs[2] = '{1'b1, 7'd3, 56'h0, 56'h00_00_00_00_FF_5A_A5, 288};
    vecs[3] = '{1'b0, 7'd0, 56'h0, 56'h0, 72};
    vecs[4] = '{1'b1, 7'd0, 56'h0, 56'h0, 72};
    vecs[5] = '{1'b0, 7'd7, 56'h17_16_15_14_13_12_11, 56'h0, 576};
    vecs[6] = '{1'b1, 7'd7, 56'h0, 56'h17_16_15_14_13_12_11, 576};
    post    = '{1'b1, 7'd3, 56'h0, 56'h00_00_00_00_13_12_11, 288};

    repeat (2) @(negedge clk);
    check("rst spi_cs",   32'(bus.spi_cs),   32'd1);
    check("rst spi_sclk", 32'(bus.spi_sclk), 32'd0);
    check("rst spi_mosi", 32'(bus.spi_mosi), 32'd0);
    check("rst busy",     32'(bus.busy),     32'd0);
    check("rst done",     32'(bus.done),     32'd0);
    check("rst wr_req",   32'(bus.wr_req),   32'd0);
    check("rst rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst rd_data",  32'(bus.rd_data),  32'd0);
    for (int k = 0; k < 7; k++)
      check($sformatf("rst param%0d", k), 32'(param_at(k)), 32'(rst_params[k]));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("release spi_cs",   32'(bus.spi_cs),   32'd1);
    check("release spi_sclk", 32'(bus.spi_sclk), 32'd0);
    check("release rises",    32'(rises),        32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    for (int k = 0; k < 7; k++) begin
`ifdef USER_PARAM_MASTER_MIRROR_EN
      exp_p = 8'h11 + 8'(k);
`else
      exp_p = rst_params[k];
`endif
      check($sformatf("param%0d", k), 32'(param_at(k)), 32'(exp_p));
    end

    // A second start while busy must be dropped
    @(posedge clk);
    d0 = dones; f0 = cs_falls; m0 = mosi_log.size(); q0 = rd_log.size();
    pulse_start(1'b1, 7'd1);
    repeat (10) @(negedge clk);
    check("busy during txn", 32'(bus.busy), 32'd1);
    pulse_start(1'b0, 7'd5);
    wait_idle("busy_start");
    repeat (20) @(negedge clk);
    @(posedge clk);
    check("busy_start cs_falls", 32'(cs_falls - f0), 32'd1);
    check("busy_start done",     32'(dones - d0), 32'd1);
    check("busy_start mosi_cnt", 32'(mosi_log.size() - m0), 32'd2);
    if (m0 < mosi_log.size()) check("busy_start cmd", 32'(mosi_log[m0]), 32'h81);
    if (q0 < rd_log.size())   check("busy_start rd",  32'(rd_log[q0]), 32'h11);

    // Reset in the middle of the third byte of a read
    @(posedge clk);
    r0 = rises; d0 = dones;
    pulse_start(1'b1, 7'd7);
    n = 0;
    while ((rises - r0) < 20 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("midreset reached", 32'(rises - r0 >= 20), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset spi_cs",   32'(bus.spi_cs),   32'd1);
    check("midreset spi_sclk", 32'(bus.spi_sclk), 32'd0);
    check("midreset busy",     32'(bus.busy),     32'd0);
    check("midreset spi_mosi", 32'(bus.spi_mosi), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    check("midreset no done", 32'(dones - d0), 32'd0);
    run_vec(post, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
